// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 program loader: loader FSM states and bus widths.
package mu0_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 2 * BYTE_W;
  localparam int MU0_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mu0_ram_loader.sv
// Pairs incoming bytes (high first) into words and writes them to MU0 RAM from address 0,
// holding the CPU in reset while loading. Optional MU0_LOADER_CHECKSUM_EN adds a word checksum.
module mu0_ram_loader
  import mu0_pkg::*;
#(
  parameter int ADDR_W = MU0_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
`ifdef MU0_LOADER_CHECKSUM_EN
  output logic [WORD_W-1:0] checksum,
`endif
  output state_t            dbg_state
);

  // Byte handshake: a byte moves on a rising edge where byte_valid && byte_ready.
  // byte_ready depends only on state (HI/LO), never on byte_valid.

  state_t state, next_state;
  logic   last_q;
  logic   accept;
  logic   addr_at_top;

  assign accept      = byte_valid && byte_ready;
  assign addr_at_top = &ram_addr;
  assign dbg_state   = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    ram_we     = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) next_state = HI;
      end
      HI: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) next_state = byte_last ? WR : LO;
      end
      LO: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) next_state = WR;
      end
      WR: begin
        ram_we     = 1'b1;
        cpu_hold   = 1'b1;
        // Writing the top address ends the session even without a last byte.
        next_state = (last_q || addr_at_top) ? DONE : HI;
      end
      DONE: begin
        cpu_hold   = 1'b1;
        load_done  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      word_count <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            ram_addr   <= '0;
            word_count <= '0;
            last_q     <= 1'b0;
          end
        end
        HI: begin
          if (accept) begin
            ram_wdata[WORD_W-1:BYTE_W] <= byte_in;
            last_q                     <= byte_last;
            if (byte_last) ram_wdata[BYTE_W-1:0] <= '0;
          end
        end
        LO: begin
          if (accept) begin
            ram_wdata[BYTE_W-1:0] <= byte_in;
            last_q                <= byte_last;
          end
        end
        WR: begin
          ram_addr   <= ram_addr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MU0_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            checksum <= '0;
    else if (state == IDLE && load_start)    checksum <= '0;
    else if (state == WR)                    checksum <= checksum + ram_wdata;
  end
`endif

endmodule

// File: tb/tb_mu0_ram_loader.sv
// Directed self-checking bench for mu0_ram_loader with a write scoreboard.
module tb_mu0_ram_loader;
  import mu0_pkg::*;

  localparam int AW = 12;

  logic          clock;
  logic          reset_n;
  logic          load_start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_last;
  logic          byte_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
  state_t        dbg_state;
`ifdef MU0_LOADER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  logic [AW+15:0] exp_q[$];

  mu0_ram_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_start (load_start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .word_count (word_count),
`ifdef MU0_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (reset_n && ram_we) begin
      logic [AW+15:0] e;
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {4'h0, ram_addr, ram_wdata}, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e[AW+15:16]));
        check("wr_data", 32'(ram_wdata), 32'(e[15:0]));
      end
    end
  end

  task automatic expect_write(input int addr, input logic [15:0] data);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    exp_q.push_back({a, data});
  endtask

  task automatic pulse_start();
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int tmo;
    @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    byte_last  = last;
    tmo = 0;
    while (!byte_ready && tmo < 50) begin
      @(negedge clock);
      tmo++;
    end
    if (tmo >= 50) check("byte_ready_timeout", 32'(tmo), 32'd0);
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_in    = 8'($urandom_range(0, 255));
    repeat (gap) @(negedge clock);
  endtask

  task automatic wait_done(input string tag, input int exp_count);
    int tmo;
    tmo = 0;
    @(negedge clock);
    while (!load_done && tmo < 100) begin
      @(negedge clock);
      tmo++;
    end
    check({tag, "_done_seen"}, 32'(load_done), 32'd1);
    check({tag, "_count"}, 32'(word_count), 32'(exp_count));
    check({tag, "_hold_in_done"}, 32'(cpu_hold), 32'd1);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, 32'(load_done), 32'd0);
    check({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int we_base;
    reset_n    = 1'b0;
    load_start = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset_n = 1'b1;

    // 1: four bytes, two words; low-byte -> ram_we latency
    pulse_start();
    check("t1_hold", 32'(cpu_hold), 32'd1);
    check("t1_ready", 32'(byte_ready), 32'd1);
    expect_write(0, 16'h1234);
    expect_write(1, 16'h5678);
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    @(negedge clock);
    check("t1_we_latency", 32'(ram_we), 32'd1);
    check("t1_ready_in_wr", 32'(byte_ready), 32'd0);
    send_byte(8'h56, 1'b0, 0);
    send_byte(8'h78, 1'b1, 0);
    wait_done("t1", 2);

    // 2: odd byte count, last word padded
    pulse_start();
    check("t2_count_cleared", 32'(word_count), 32'd0);
    expect_write(0, 16'hABCD);
    expect_write(1, 16'hEF00);
    send_byte(8'hAB, 1'b0, 0);
    send_byte(8'hCD, 1'b0, 0);
    send_byte(8'hEF, 1'b1, 0);
    wait_done("t2", 2);

    // 3: gapped bytes, mid-session load_start ignored
    we_base = we_cnt;
    pulse_start();
    expect_write(0, 16'h1122);
    expect_write(1, 16'h3344);
    expect_write(2, 16'h5566);
    send_byte(8'h11, 1'b0, $urandom_range(0, 3));
    send_byte(8'h22, 1'b0, $urandom_range(1, 3));
    pulse_start();
    check("t3_start_ignored_count", 32'(word_count), 32'd1);
    check("t3_start_ignored_addr", 32'(ram_addr), 32'd1);
    send_byte(8'h33, 1'b0, $urandom_range(0, 3));
    send_byte(8'h44, 1'b0, $urandom_range(0, 3));
    send_byte(8'h55, 1'b0, $urandom_range(0, 3));
    send_byte(8'h66, 1'b1, $urandom_range(0, 3));
    wait_done("t3", 3);
    check("t3_we_per_word", 32'(we_cnt - we_base), 32'd3);

    // 4: full address space without last -> forced DONE, address wraps
    we_base = we_cnt;
    pulse_start();
    for (int i = 0; i < (1 << AW); i++) begin
      logic [11:0] iv;
      iv = 12'(i);
      expect_write(i, {iv[11:4], iv[3:0], ~iv[3:0]});
      send_byte(iv[11:4], 1'b0, 0);
      send_byte({iv[3:0], ~iv[3:0]}, 1'b0, 0);
    end
    wait_done("t4", 1 << AW);
    check("t4_addr_wrapped", 32'(ram_addr), 32'd0);
    check("t4_we_total", 32'(we_cnt - we_base), 32'(1 << AW));

    // 5: reset after high byte aborts without a write, then reload
    pulse_start();
    send_byte(8'hC3, 1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("t5_abort");
    repeat (2) @(negedge clock);
    check("t5_no_write_in_reset", 32'(ram_we), 32'd0);
    reset_n = 1'b1;
    pulse_start();
    expect_write(0, 16'h9ABC);
    send_byte(8'h9A, 1'b0, 0);
    send_byte(8'hBC, 1'b1, 0);
    wait_done("t5", 1);

`ifdef MU0_LOADER_CHECKSUM_EN
    // 6: checksum wraps modulo 2^16
    pulse_start();
    check("t6_cksum_cleared", 32'(checksum), 32'd0);
    expect_write(0, 16'hFFFF);
    expect_write(1, 16'h0002);
    send_byte(8'hFF, 1'b0, 0);
    send_byte(8'hFF, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h02, 1'b1, 0);
    wait_done("t6", 2);
    check("t6_cksum", 32'(checksum), 32'h0001);
    repeat (2) @(negedge clock);
    check("t6_cksum_hold", 32'(checksum), 32'h0001);
`endif

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
